// File: rtl/lcd_text_writer.sv
// Screen-image feeder for the character LCD controller: holds a 2x16 character
// buffer and streams it as 34 paced transfers (address, 16 chars, address, 16 chars).
module lcd_text_writer #(
  parameter int GAP   = 104,
  parameter int GBITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic       active,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  localparam logic [GBITS-1:0] GAP_LOAD  = GBITS'(GAP - 1);
  localparam logic [5:0]       LAST_XFER = 6'd33;
  localparam logic [5:0]       LINE2_CMD = 6'd17;

  state_t           state, state_next;
  logic [5:0]       t, t_next;
  logic [GBITS-1:0] cnt, cnt_next;
  logic             enable_next, active_next, done_next;
  logic [9:0]       bus_next;

  logic [7:0] buffer [32];
  logic [4:0] data_idx;
  logic [9:0] xfer_word;

  // Host writes land at any time; reset blanks the screen to spaces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
    end else if (wr_en) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  // Transfers 1..16 carry buf[0..15]; 18..33 carry buf[16..31].
  always_comb begin
    data_idx = (t <= 6'd16) ? 5'(t - 6'd1) : 5'(t - 6'd2);
    if (t == 6'd0)
      xfer_word = 10'h080;
    else if (t == LINE2_CMD)
      xfer_word = 10'h0C0;
    else
      xfer_word = {2'b10, buffer[data_idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      t          <= '0;
      cnt        <= '0;
      lcd_enable <= 1'b0;
      lcd_bus    <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      t          <= t_next;
      cnt        <= cnt_next;
      lcd_enable <= enable_next;
      lcd_bus    <= bus_next;
      active     <= active_next;
      done       <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    t_next      = t;
    cnt_next    = cnt;
    enable_next = 1'b0;
    bus_next    = '0;
    active_next = active;
    done_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next  = S_ISSUE;
          t_next      = '0;
          active_next = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!busy) begin
          enable_next = 1'b1;
          bus_next    = xfer_word;
          cnt_next    = GAP_LOAD;
          state_next  = S_GAP;
        end
      end
      S_GAP: begin
        // The gap always runs to completion regardless of busy.
        if (cnt == '0) begin
          if (t == LAST_XFER) begin
            state_next  = S_IDLE;
            done_next   = 1'b1;
            active_next = 1'b0;
          end else begin
            t_next     = t + 6'd1;
            state_next = S_ISSUE;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer: captures every lcd_enable transfer with its
// cycle number and checks contents, pacing, stalls, live edits and aborts.
module tb_lcd_text_writer;

  localparam int PERIOD = 105;
  localparam int GAPV   = 104;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy = 1'b0;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       active;
  logic       done;

  lcd_text_writer #(.GAP(104), .GBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .lcd_enable(lcd_enable), .lcd_bus(lcd_bus),
    .active(active), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_wr;
    logic [4:0] addr;
    logic [7:0] data;
    int         tidx;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [9:0] cap_bus[$];
  int         cap_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         bus_leak = 0;
  logic [7:0] model_buf [32];

  // Transfer monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (lcd_enable) begin
      cap_bus.push_back(lcd_bus);
      cap_cyc.push_back(cyc);
    end else if (lcd_bus != 10'h000) begin
      bus_leak++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int cap_at(input int i);
    if (i >= 0 && i < cap_bus.size()) return int'(cap_bus[i]);
    return -1;
  endfunction

  function automatic int cyc_at(input int i);
    if (i >= 0 && i < cap_cyc.size()) return cap_cyc[i];
    return -1;
  endfunction

  function automatic int bad_spacing(input int gap);
    int n = 0;
    for (int i = 1; i < cap_cyc.size(); i++)
      if (cap_cyc[i] - cap_cyc[i-1] != gap) n++;
    return n;
  endfunction

  function automatic logic [9:0] exp_bus(input int t);
    if (t == 0)  return 10'h080;
    if (t == 17) return 10'h0C0;
    if (t <= 16) return {2'b10, model_buf[t-1]};
    return {2'b10, model_buf[t-2]};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model_buf[a] = d;
  endtask

  task automatic clear_capture();
    cap_bus.delete();
    cap_cyc.delete();
  endtask

  task automatic pulse_start(output int sc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_done(input int limit);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output("done_arrived", done_cnt - base, 1);
  endtask

  task automatic wait_xfers(input int count, input int limit);
    int n = 0;
    while (cap_bus.size() < count && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output($sformatf("xfer_reached_%0d", count), int'(cap_bus.size() >= count), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_enable"}, int'(lcd_enable), 0);
    check_output({tag, "_bus"}, int'(lcd_bus), 0);
    check_output({tag, "_active"}, int'(active), 0);
    check_output({tag, "_done"}, int'(done), 0);
  endtask

  task automatic add_vec(input bit w, input logic [4:0] a, input logic [7:0] d,
                         input int t, input logic [9:0] e);
    vec_t v;
    v.do_wr = w; v.addr = a; v.data = d; v.tidx = t; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int sc;
    int bf;
    int target;
    int n_before;
    int d_before;

    add_vec(1'b1, 5'd0,  8'h48, 1,  10'h248);
    add_vec(1'b1, 5'd1,  8'h45, 2,  10'h245);
    add_vec(1'b1, 5'd2,  8'h4C, 3,  10'h24C);
    add_vec(1'b1, 5'd3,  8'h4C, 4,  10'h24C);
    add_vec(1'b1, 5'd4,  8'h4F, 5,  10'h24F);
    add_vec(1'b1, 5'd16, 8'h57, 18, 10'h257);
    add_vec(1'b1, 5'd17, 8'h4F, 19, 10'h24F);
    add_vec(1'b1, 5'd18, 8'h52, 20, 10'h252);
    add_vec(1'b1, 5'd19, 8'h4C, 21, 10'h24C);
    add_vec(1'b1, 5'd20, 8'h44, 22, 10'h244);
    add_vec(1'b0, 5'd0,  8'h00, 0,  10'h080);
    add_vec(1'b0, 5'd0,  8'h00, 6,  10'h220);
    add_vec(1'b0, 5'd0,  8'h00, 16, 10'h220);
    add_vec(1'b0, 5'd0,  8'h00, 17, 10'h0C0);
    add_vec(1'b0, 5'd0,  8'h00, 33, 10'h220);

    // Reset state, then a refresh of the blank screen.
    reset_model();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    clear_capture();
    pulse_start(sc);
    check_output("start_active", int'(active), 1);
    wait_done(5000);
    check_output("blank_count", cap_bus.size(), 34);
    for (int t = 0; t < 34; t++)
      check_output($sformatf("blank_xfer%0d", t), cap_at(t), int'(exp_bus(t)));
    check_output("blank_first_latency", cyc_at(0), sc + 1);
    check_output("blank_spacing", bad_spacing(PERIOD), 0);
    check_output("blank_done_delay", done_cyc - cyc_at(33), GAPV);
    check_output("blank_done_active", int'(active), 0);

    // HELLO / WORLD through the vector table, with ignored start pulses.
    foreach (vecs[i])
      if (vecs[i].do_wr) write_char(vecs[i].addr, vecs[i].data);
    clear_capture();
    pulse_start(sc);
    wait_xfers(3, 1000);
    pulse_start(bf);
    wait_xfers(20, 3000);
    pulse_start(bf);
    wait_xfers(30, 2000);
    start = 1'b1;
    wait_done(2000);
    foreach (vecs[i])
      check_output($sformatf("table_xfer%0d", vecs[i].tidx), cap_at(vecs[i].tidx), int'(vecs[i].exp));
    check_output("table_count", cap_bus.size(), 34);
    check_output("table_spacing", bad_spacing(PERIOD), 0);
    check_output("table_total_span", cyc_at(33) - cyc_at(0), 33 * PERIOD);
    check_output("table_done_time", done_cyc, sc + 1 + 33 * PERIOD + GAPV);
    check_output("table_done_active", int'(active), 0);

    // Start held high re-triggers one edge after done; then abort at transfer 20.
    clear_capture();
    @(negedge clk);
    check_output("retrigger_active", int'(active), 1);
    start = 1'b0;
    wait_xfers(21, 3000);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    n_before = cap_bus.size();
    d_before = done_cnt;
    repeat (400) @(negedge clk);
    check_output("abort_no_enables", cap_bus.size(), n_before);
    check_output("abort_no_done", done_cnt, d_before);
    check_output("abort_idle_active", int'(active), 0);

    // Busy stall of 50 cycles when transfer 5 reaches issue.
    for (int i = 0; i < 32; i++) write_char(5'(i), 8'(8'h41 + i));
    clear_capture();
    pulse_start(sc);
    wait_xfers(5, 1000);
    busy = 1'b1;
    repeat (154) @(negedge clk);
    busy = 1'b0;
    wait_done(6000);
    check_output("stall_count", cap_bus.size(), 34);
    for (int t = 0; t < 34; t++)
      check_output($sformatf("stall_xfer%0d", t), cap_at(t), int'(exp_bus(t)));
    check_output("stall_slip", cyc_at(5) - cyc_at(4), PERIOD + 50);
    check_output("stall_span", cyc_at(33) - cyc_at(0), 33 * PERIOD + 50);
    check_output("stall_done_time", done_cyc, sc + 1 + 33 * PERIOD + GAPV + 50);

    // Start while the controller is still initialising, then live edits.
    busy = 1'b1;
    clear_capture();
    pulse_start(sc);
    repeat (2000) @(negedge clk);
    check_output("init_no_enable", cap_bus.size(), 0);
    check_output("init_waiting_active", int'(active), 1);
    busy = 1'b0;
    bf = cyc;
    wait_xfers(1, 10);
    check_output("init_first_enable", cyc_at(0), bf + 1);
    wait_xfers(11, 2000);
    write_char(5'd31, 8'h21);
    write_char(5'd0, 8'h58);
    target = cyc_at(0) + 22 * PERIOD;
    while (cyc < target - 1) @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'h7A;
    @(negedge clk);
    wr_en = 1'b0;
    model_buf[20] = 8'h7A;
    wait_done(3000);
    check_output("live_xfer33", cap_at(33), 10'h221);
    check_output("live_xfer1_unchanged", cap_at(1), 10'h241);
    check_output("same_edge_xfer22_old", cap_at(22), 10'h255);
    check_output("live_xfer21", cap_at(21), 10'h254);
    check_output("live_spacing", bad_spacing(PERIOD), 0);

    check_output("bus_zero_between_enables", bus_leak, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
